// File: rtl/mem_lsu.sv
// Load/store unit: one EX/MEM access at a time over a req/ack data-memory bus, with timeout abort.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus cycle.
module mem_lsu #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [1:0]  i_ctrlMEM,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_memAddr,
  input  logic [31:0] i_writeData,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_readData,
  output logic        o_busReq,
  output logic        o_busWe,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWdata,
  output logic [3:0]  o_busBe,
  input  logic        i_busAck,
  input  logic [31:0] i_busRdata,
  output logic [1:0]  o_dbgState
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access;
  logic [3:0]  be_c;
  logic [1:0]  off_c;
  logic [31:0] wrep_c;
  logic [31:0] shifted;
  logic [31:0] ext_c;

  assign access = i_valid & (|i_ctrlMEM);

  // Lane selection: low address bits below the access size are ignored.
  always_comb begin
    be_c   = 4'b1111;
    off_c  = 2'b00;
    wrep_c = i_writeData;
    case (i_funct3[1:0])
      2'b00: begin
        be_c   = 4'b0001 << i_memAddr[1:0];
        off_c  = i_memAddr[1:0];
        wrep_c = {4{i_writeData[7:0]}};
      end
      2'b01: begin
        be_c   = 4'b0011 << {i_memAddr[1], 1'b0};
        off_c  = {i_memAddr[1], 1'b0};
        wrep_c = {2{i_writeData[15:0]}};
      end
      default: begin
        be_c   = 4'b1111;
        off_c  = 2'b00;
        wrep_c = i_writeData;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((i_funct3[1:0] == 2'b01) & i_memAddr[0]) |
                    (i_funct3[1] & (|i_memAddr[1:0]));
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d  = {i_memAddr[31:2], 2'b00};
          we_d    = i_ctrlMEM[0];
          be_d    = be_c;
          wdata_d = i_ctrlMEM[0] ? wrep_c : 32'h0;
          off_d   = off_c;
          f3_d    = i_funct3;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_BUS;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUS: begin
        if (i_busAck) begin
          rdata_d = i_busRdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Right-align the addressed lane, then sign- or zero-extend by size.
  assign shifted = rdata_q >> {off_q, 3'b000};
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ext_c = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   ext_c = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
      default: ext_c = shifted;
    endcase
  end

  assign o_stall    = access & (state_q != S_DONE);
  assign o_done     = (state_q == S_DONE);
  assign o_err      = (state_q == S_DONE) & err_q;
  assign o_readData = ((state_q == S_DONE) && !err_q && !we_q) ? ext_c : 32'h0;
  assign o_busReq   = (state_q == S_BUS);
  assign o_busWe    = we_q;
  assign o_busAddr  = addr_q;
  assign o_busWdata = wdata_q;
  assign o_busBe    = be_q;
  assign o_dbgState = state_q;

endmodule
